// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch address generator.
// Tag fields are sized for the widest supported configuration; narrower builds
// use the low bits and leave the rest zero.
package fetch_pkg;

    localparam int SLOT_W_MAX  = 3;
    localparam int EPOCH_W_MAX = 8;
    localparam int FETCH_WIDTH_DEF = 2;

    typedef enum logic [1:0] {
        S_BOOT,
        S_IDLE,
        S_REQ
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]            pc;
        logic [SLOT_W_MAX-1:0]  first_slot;
        logic [EPOCH_W_MAX-1:0] epoch;
    } fetch_tag_t;

    // Bytes covered by one burst of fw 32-bit instructions.
    function automatic int fetch_bytes(input int fw);
        return 4 * fw;
    endfunction

    // Round an address down to the start of its burst.
    function automatic logic [31:0] align_addr(input logic [31:0] a, input int fw);
        return a & ~(32'(fetch_bytes(fw)) - 32'd1);
    endfunction

    // Instruction index of an address inside its burst.
    function automatic logic [SLOT_W_MAX-1:0] slot_of(input logic [31:0] a, input int fw);
        return SLOT_W_MAX'((a >> 2) & (32'(fw) - 32'd1));
    endfunction

endpackage

// File: rtl/fetch_tag_fifo.sv
// Small synchronous FIFO holding the tag of every accepted, not yet completed
// burst. Push and pop may happen in the same cycle, including when full.
module fetch_tag_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_tag_t                   push_data,
    input  logic                         pop,
    output fetch_tag_t                   head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_tag_t        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              wr_en;
    logic              rd_en;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign head  = mem[rd_ptr];

    // Tag storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_addr_gen.sv
// Instruction-fetch address generator: issues aligned INCR bursts on the AXI
// AR channel, limits in-flight bursts by count and by fetch-buffer credit, and
// tags each burst with an epoch so data fetched before a redirect is dropped.
module fetch_addr_gen
    import fetch_pkg::*;
#(
    parameter int          FETCH_WIDTH     = FETCH_WIDTH_DEF,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          BUF_DEPTH       = 16,
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter int          EPOCH_W         = 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              stall,
    input  logic                                              redirect_valid,
    input  logic [31:0]                                       redirect_addr,
    input  logic [$clog2(BUF_DEPTH+1)-1:0]                    buf_free,
    output logic                                              arvalid,
    output logic [31:0]                                       araddr,
    output logic [1:0]                                        arburst,
    output logic [2:0]                                        arsize,
    output logic [7:0]                                        arlen,
    input  logic                                              arready,
    input  logic                                              r_done,
    output logic                                              resp_valid,
    output logic [31:0]                                       resp_pc,
    output logic [(FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1)-1:0] resp_first_slot,
    output logic                                              resp_stale,
    output logic [EPOCH_W-1:0]                                epoch,
    output logic                                              err_underflow
);

    localparam int          SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int          CNT_W       = $clog2(MAX_OUTSTANDING+1);
    localparam int          CW          = $clog2(BUF_DEPTH) + $clog2(MAX_OUTSTANDING) + 2;
    localparam logic [31:0] FETCH_BYTES = 32'(fetch_bytes(FETCH_WIDTH));

    fetch_state_t           state;
    logic                   arvalid_q;
    logic [31:0]            araddr_q;
    logic [SLOT_W_MAX-1:0]  cur_slot;
    logic [EPOCH_W-1:0]     epoch_q;
    logic [EPOCH_W-1:0]     addr_epoch;
    logic [EPOCH_W-1:0]     epoch_nxt;
    logic                   pend_valid;
    logic [31:0]            pend_addr;
    logic [31:0]            tgt_addr;
    logic                   err_q;

    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    fetch_tag_t             head;
    fetch_tag_t             push_tag;

    logic [CW-1:0]          outs_next;
    logic [CW-1:0]          need;
    logic                   can_issue;

    assign push = (state == S_REQ) & arready;
    assign pop  = r_done & ~fifo_empty;

    // Outstanding count as it will stand after this cycle, including a burst
    // handshaking right now; otherwise a back-to-back AR could be raised that
    // the tag FIFO has no room for and that AXI would not let us withdraw.
    assign outs_next = CW'(fifo_count) + CW'(push) - CW'(pop);
    assign need      = CW'(FETCH_WIDTH) * (outs_next + CW'(1));
    assign can_issue = ~stall & (outs_next < CW'(MAX_OUTSTANDING)) & (CW'(buf_free) >= need);

    assign epoch_nxt = epoch_q + EPOCH_W'(redirect_valid);
    assign tgt_addr  = redirect_valid ? redirect_addr : pend_addr;

    assign push_tag.pc         = araddr_q;
    assign push_tag.first_slot = cur_slot;
    assign push_tag.epoch      = EPOCH_W_MAX'(addr_epoch);

    fetch_tag_fifo #(
        .DEPTH     (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_tag),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign arvalid         = arvalid_q;
    assign araddr          = araddr_q;
    assign arburst         = 2'b01;
    assign arsize          = 3'd2;
    assign arlen           = 8'(FETCH_WIDTH - 1);
    assign resp_valid      = ~fifo_empty;
    assign resp_pc         = head.pc;
    assign resp_first_slot = SLOT_W'(head.first_slot);
    assign resp_stale      = (head.epoch != EPOCH_W_MAX'(epoch_q));
    assign epoch           = epoch_q;
    assign err_underflow   = err_q;

    // Request FSM with the address, epoch and pending-redirect registers; a held AR never changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_BOOT;
            arvalid_q  <= 1'b0;
            araddr_q   <= RESET_PC;
            cur_slot   <= '0;
            epoch_q    <= '0;
            addr_epoch <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            err_q      <= 1'b0;
        end else begin
            epoch_q <= epoch_nxt;
            if (r_done && fifo_empty) begin
                err_q <= 1'b1;
            end
            case (state)
                S_BOOT, S_IDLE: begin
                    if (redirect_valid) begin
                        araddr_q   <= align_addr(redirect_addr, FETCH_WIDTH);
                        cur_slot   <= slot_of(redirect_addr, FETCH_WIDTH);
                        addr_epoch <= epoch_nxt;
                    end
                    if (state == S_IDLE && can_issue) begin
                        state     <= S_REQ;
                        arvalid_q <= 1'b1;
                    end else begin
                        state     <= S_IDLE;
                        arvalid_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (arready) begin
                        if (redirect_valid || pend_valid) begin
                            araddr_q <= align_addr(tgt_addr, FETCH_WIDTH);
                            cur_slot <= slot_of(tgt_addr, FETCH_WIDTH);
                        end else begin
                            araddr_q <= araddr_q + FETCH_BYTES;
                            cur_slot <= '0;
                        end
                        addr_epoch <= epoch_nxt;
                        pend_valid <= 1'b0;
                        if (!can_issue) begin
                            state     <= S_IDLE;
                            arvalid_q <= 1'b0;
                        end
                    end else if (redirect_valid) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= redirect_addr;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    arvalid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Directed bench for fetch_addr_gen (FETCH_WIDTH=2, MAX_OUTSTANDING=4,
// BUF_DEPTH=16). Expected AR addresses and their tags are queued as each step
// is set up; the scoreboard pops them on AR handshakes and again on r_done.
module tb_fetch_addr_gen;

    typedef struct {
        logic [31:0] addr;
        logic        slot;
        logic [1:0]  ep;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [4:0]  buf_free;
    logic        arvalid;
    logic [31:0] araddr;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic        arready;
    logic        r_done;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic [0:0]  resp_first_slot;
    logic        resp_stale;
    logic [1:0]  epoch;
    logic        err_underflow;

    exp_t        exp_ar[$];
    exp_t        exp_resp[$];
    logic [1:0]  m_epoch;
    int          checks;
    int          passed;
    int          failed;

    fetch_addr_gen #(
        .FETCH_WIDTH     (2),
        .MAX_OUTSTANDING (4),
        .BUF_DEPTH       (16),
        .RESET_PC        (32'h0),
        .EPOCH_W         (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .buf_free        (buf_free),
        .arvalid         (arvalid),
        .araddr          (araddr),
        .arburst         (arburst),
        .arsize          (arsize),
        .arlen           (arlen),
        .arready         (arready),
        .r_done          (r_done),
        .resp_valid      (resp_valid),
        .resp_pc         (resp_pc),
        .resp_first_slot (resp_first_slot),
        .resp_stale      (resp_stale),
        .epoch           (epoch),
        .err_underflow   (err_underflow)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic slot, input logic [1:0] ep);
        exp_t e;
        e.addr = addr;
        e.slot = slot;
        e.ep   = ep;
        exp_ar.push_back(e);
    endtask

    // One clock: score the handshake / completion about to happen, then sample #1 after the edge.
    task automatic step_cycle();
        exp_t e;
        if (!rst) begin
            if (arvalid && arready) begin
                check_output("ar_expected", 32'(exp_ar.size() != 0), 32'd1);
                if (exp_ar.size() != 0) begin
                    e = exp_ar.pop_front();
                    check_output("ar_addr", araddr, e.addr);
                    exp_resp.push_back(e);
                end
            end
            if (r_done && exp_resp.size() != 0) begin
                e = exp_resp.pop_front();
                check_output("resp_valid", 32'(resp_valid), 32'd1);
                check_output("resp_pc", resp_pc, e.addr);
                check_output("resp_first_slot", 32'(resp_first_slot), 32'(e.slot));
                check_output("resp_stale", 32'(resp_stale), 32'(e.ep != m_epoch));
            end
        end
        @(posedge clk);
        #1;
        if (!rst && redirect_valid) begin
            m_epoch = m_epoch + 2'd1;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        arready        = 1'b0;
        r_done         = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step_cycle();
        rst = 1'b0;
        exp_ar.delete();
        exp_resp.delete();
        m_epoch = 2'd0;
    endtask

    // Directed sequence covering issue, credit, redirect, wrap, underflow and reset.
    initial begin
        checks = 0;
        passed = 0;
        failed = 0;
        m_epoch = 2'd0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr = 32'h0;
        buf_free = 5'd16;
        arready = 1'b0;
        r_done = 1'b0;

        // Reset values and back-to-back issue until four are outstanding
        do_reset();
        check_output("rst_arvalid", 32'(arvalid), 32'd0);
        check_output("rst_araddr", araddr, 32'h0);
        check_output("rst_epoch", 32'(epoch), 32'd0);
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_err", 32'(err_underflow), 32'd0);
        check_output("arburst", 32'(arburst), 32'd1);
        check_output("arsize", 32'(arsize), 32'd2);
        check_output("arlen", 32'(arlen), 32'd1);
        arready = 1'b1;
        push_exp(32'h0, 1'b0, 2'd0);
        push_exp(32'h8, 1'b0, 2'd0);
        push_exp(32'h10, 1'b0, 2'd0);
        push_exp(32'h18, 1'b0, 2'd0);
        step_cycle();
        check_output("s1_arvalid_c1", 32'(arvalid), 32'd0);
        step_cycle();
        check_output("s1_arvalid_c2", 32'(arvalid), 32'd1);
        repeat (4) step_cycle();
        check_output("s1_stop_at_4", 32'(arvalid), 32'd0);
        check_output("s1_all_issued", 32'(exp_ar.size()), 32'd0);
        repeat (2) step_cycle();
        check_output("s1_still_stopped", 32'(arvalid), 32'd0);
        check_output("s1_head_pc", resp_pc, 32'h0);
        stall = 1'b1;
        r_done = 1'b1;
        repeat (4) step_cycle();
        r_done = 1'b0;
        check_output("s1_drained", 32'(resp_valid), 32'd0);

        // AR held without ready; redirect lands in the pending register
        do_reset();
        push_exp(32'h0, 1'b0, 2'd0);
        repeat (2) step_cycle();
        check_output("s2_arvalid", 32'(arvalid), 32'd1);
        step_cycle();
        redirect_valid = 1'b1;
        redirect_addr = 32'h106;
        step_cycle();
        redirect_valid = 1'b0;
        check_output("s2_epoch", 32'(epoch), 32'd1);
        check_output("s2_hold_addr", araddr, 32'h0);
        repeat (3) step_cycle();
        check_output("s2_hold_addr_end", araddr, 32'h0);
        check_output("s2_hold_valid", 32'(arvalid), 32'd1);
        push_exp(32'h100, 1'b1, 2'd1);
        arready = 1'b1;
        step_cycle();
        check_output("s2_redirect_addr", araddr, 32'h100);
        stall = 1'b1;
        step_cycle();
        check_output("s2_idle", 32'(arvalid), 32'd0);
        check_output("s2_old_stale", 32'(resp_stale), 32'd1);
        r_done = 1'b1;
        repeat (2) step_cycle();
        r_done = 1'b0;

        // Credit check: three free slots cannot cover a second burst
        stall = 1'b0;
        push_exp(32'h108, 1'b0, 2'd1);
        step_cycle();
        buf_free = 5'd3;
        step_cycle();
        check_output("s3_after_one", 32'(arvalid), 32'd0);
        repeat (3) step_cycle();
        check_output("s3_no_credit", 32'(arvalid), 32'd0);
        buf_free = 5'd4;
        push_exp(32'h110, 1'b0, 2'd1);
        step_cycle();
        check_output("s3_credit_ok", 32'(arvalid), 32'd1);
        check_output("s3_addr", araddr, 32'h110);
        step_cycle();
        check_output("s3_credit_again", 32'(arvalid), 32'd0);

        // Completion frees a slot; push and pop together keep the count
        buf_free = 5'd16;
        push_exp(32'h118, 1'b0, 2'd1);
        push_exp(32'h120, 1'b0, 2'd1);
        repeat (3) step_cycle();
        check_output("s4_full", 32'(arvalid), 32'd0);
        push_exp(32'h128, 1'b0, 2'd1);
        r_done = 1'b1;
        step_cycle();
        check_output("s4_reissue", 32'(arvalid), 32'd1);
        check_output("s4_reissue_addr", araddr, 32'h128);
        step_cycle();
        r_done = 1'b0;
        check_output("s4_push_pop_stay", 32'(arvalid), 32'd1);
        push_exp(32'h130, 1'b0, 2'd1);
        step_cycle();
        check_output("s4_count_full", 32'(arvalid), 32'd0);
        stall = 1'b1;
        r_done = 1'b1;
        repeat (4) step_cycle();
        r_done = 1'b0;
        check_output("s4_drained", 32'(resp_valid), 32'd0);

        // Address wrap at the top of memory, then underflow
        redirect_valid = 1'b1;
        redirect_addr = 32'hFFFF_FFF9;
        step_cycle();
        redirect_valid = 1'b0;
        check_output("s5_redirect_addr", araddr, 32'hFFFF_FFF8);
        check_output("s5_epoch", 32'(epoch), 32'd2);
        stall = 1'b0;
        push_exp(32'hFFFF_FFF8, 1'b0, 2'd2);
        push_exp(32'h0, 1'b0, 2'd2);
        repeat (2) step_cycle();
        check_output("s5_wrap", araddr, 32'h0);
        stall = 1'b1;
        step_cycle();
        r_done = 1'b1;
        repeat (2) step_cycle();
        check_output("s5_no_err_yet", 32'(err_underflow), 32'd0);
        step_cycle();
        r_done = 1'b0;
        check_output("s5_underflow", 32'(err_underflow), 32'd1);
        check_output("s5_empty", 32'(resp_valid), 32'd0);
        repeat (3) step_cycle();
        check_output("s5_sticky", 32'(err_underflow), 32'd1);

        // Reset while an AR is held with three outstanding
        stall = 1'b0;
        push_exp(32'h8, 1'b0, 2'd2);
        push_exp(32'h10, 1'b0, 2'd2);
        push_exp(32'h18, 1'b0, 2'd2);
        repeat (4) step_cycle();
        arready = 1'b0;
        step_cycle();
        check_output("s6_held", araddr, 32'h20);
        check_output("s6_inflight", 32'(resp_valid), 32'd1);
        do_reset();
        check_output("s6_arvalid", 32'(arvalid), 32'd0);
        check_output("s6_resp_valid", 32'(resp_valid), 32'd0);
        check_output("s6_araddr", araddr, 32'h0);
        check_output("s6_epoch", 32'(epoch), 32'd0);
        check_output("s6_err_clear", 32'(err_underflow), 32'd0);

        // Redirect in the handshake cycle, then two redirects back to back
        arready = 1'b1;
        push_exp(32'h0, 1'b0, 2'd0);
        repeat (2) step_cycle();
        redirect_valid = 1'b1;
        redirect_addr = 32'h40C;
        push_exp(32'h408, 1'b1, 2'd1);
        step_cycle();
        redirect_valid = 1'b0;
        check_output("s7_redirect_addr", araddr, 32'h408);
        stall = 1'b1;
        step_cycle();
        check_output("s7_idle", 32'(arvalid), 32'd0);
        r_done = 1'b1;
        repeat (2) step_cycle();
        r_done = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 32'h200;
        step_cycle();
        redirect_addr = 32'h304;
        step_cycle();
        redirect_valid = 1'b0;
        check_output("s7_last_wins", araddr, 32'h300);
        check_output("s7_epoch", 32'(epoch), 32'(m_epoch));
        check_output("s7_epoch_abs", 32'(epoch), 32'd3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
